// File: rtl/rv_mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter of the multicycle RISC-V core.
// The core control path and the debug/loader port both use this memory.
package rv_mem_pkg;

  localparam int MEM_LAT_DEF        = 2;
  localparam int DBG_STARVE_MAX_DEF = 4;

  // Wide enough for both MEM_LAT-1 and DBG_STARVE_MAX (each at most 15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

endpackage

// File: rtl/rv_arb_starve.sv
// Grant decision for the memory arbiter: the core wins by default, and a saturating
// starvation count forces a debug grant after DBG_STARVE_MAX back-to-back core wins.
module rv_arb_starve
  import rv_mem_pkg::*;
#(
  parameter int DBG_STARVE_MAX = DBG_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic dbg_req,
  input  logic arb_en,
  output logic grant_dbg,
  output logic grant_core
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DBG_STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= STARVE_MAX) begin
      return STARVE_MAX;
    end
    return v + 1'b1;
  endfunction

  always_comb begin
    grant_dbg  = arb_en && dbg_req && (!core_req || (starve_cnt == STARVE_MAX));
    grant_core = arb_en && core_req && !grant_dbg;
  end

  // Only IDLE cycles move the count; a losing debug request is the only way it grows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (grant_dbg || !dbg_req) begin
        starve_cnt <= '0;
      end else if (grant_core) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Arbiter/sequencer for the single-port unified instruction/data memory.
// It holds mem_en for MEM_LAT cycles, then returns a one-cycle ready pulse to the owner.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MEM_LAT        = MEM_LAT_DEF,
  parameter int DBG_STARVE_MAX = DBG_STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  owner_t           owner;
  logic [CNT_W-1:0] cyc_cnt;
  logic [DW-1:0]    core_rdata_q;
  logic [DW-1:0]    dbg_rdata_q;
  logic             arb_en;
  logic             grant_dbg;
  logic             grant_core;
  logic             in_access;
  logic             in_done;
  logic             own_dbg;

  assign arb_en    = (state == IDLE);
  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);
  assign own_dbg   = (owner == OWN_DBG);

  rv_arb_starve #(
    .DBG_STARVE_MAX(DBG_STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .dbg_req   (dbg_req),
    .arb_en    (arb_en),
    .grant_dbg (grant_dbg),
    .grant_core(grant_core)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_core || grant_dbg) state_nxt = ACCESS;
      ACCESS:  if (cyc_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stage: latch owner and load the access length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_CORE;
      cyc_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (arb_en && (grant_core || grant_dbg)) begin
        owner   <= grant_dbg ? OWN_DBG : OWN_CORE;
        cyc_cnt <= LAT_LOAD;
      end else if (in_access && (cyc_cnt != '0)) begin
        cyc_cnt <= cyc_cnt - 1'b1;
      end
    end
  end

  // Completion stage: the owner keeps the returned word after its ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else if (in_done) begin
      if (own_dbg) begin
        dbg_rdata_q <= mem_rdata;
      end else begin
        core_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = in_access;
    mem_we    = in_access && (own_dbg ? dbg_we : core_we);
    mem_addr  = in_access ? (own_dbg ? dbg_addr : core_addr) : '0;
    mem_wdata = in_access ? (own_dbg ? dbg_wdata : core_wdata) : '0;
  end

  // mem_rdata only becomes valid in DONE, so the ready cycle bypasses the capture register.
  always_comb begin
    core_ready = in_done && !own_dbg;
    dbg_ready  = in_done && own_dbg;
    core_rdata = core_ready ? mem_rdata : core_rdata_q;
    dbg_rdata  = dbg_ready ? mem_rdata : dbg_rdata_q;
    busy       = !arb_en;
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: dut0 (MEM_LAT=2) and dut1 (MEM_LAT=1), each driving its own memory.
// A transaction-level model checks both DUTs every cycle, and directed tests pin literal values.
module tb_rv_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_req [2];
  logic        c_we  [2];
  logic [31:0] c_addr[2];
  logic [31:0] c_wd  [2];
  logic        d_req [2];
  logic        d_we  [2];
  logic [31:0] d_addr[2];
  logic [31:0] d_wd  [2];
  logic [31:0] c_rd  [2];
  logic [31:0] d_rd  [2];
  logic        c_rdy [2];
  logic        d_rdy [2];
  logic        m_en  [2];
  logic        m_we  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [31:0] rd_q  [2];
  logic        bsy   [2];

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(2), .DBG_STARVE_MAX(4)) dut0 (
    .clk(clk), .rst(rst),
    .core_req(c_req[0]), .core_we(c_we[0]), .core_addr(c_addr[0]), .core_wdata(c_wd[0]),
    .core_rdata(c_rd[0]), .core_ready(c_rdy[0]),
    .dbg_req(d_req[0]), .dbg_we(d_we[0]), .dbg_addr(d_addr[0]), .dbg_wdata(d_wd[0]),
    .dbg_rdata(d_rd[0]), .dbg_ready(d_rdy[0]),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]),
    .mem_rdata(rd_q[0]), .busy(bsy[0])
  );

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1), .DBG_STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .core_req(c_req[1]), .core_we(c_we[1]), .core_addr(c_addr[1]), .core_wdata(c_wd[1]),
    .core_rdata(c_rd[1]), .core_ready(c_rdy[1]),
    .dbg_req(d_req[1]), .dbg_we(d_we[1]), .dbg_addr(d_addr[1]), .dbg_wdata(d_wd[1]),
    .dbg_rdata(d_rd[1]), .dbg_ready(d_rdy[1]),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]),
    .mem_rdata(rd_q[1]), .busy(bsy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] pre(input int a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h40:   return 32'hA5A50040;
      default: return 32'h01010101 * a;
    endcase
  endfunction

  // Physical memories: synchronous read, so data appears the cycle after the last mem_en.
  logic [31:0] memp [2][256];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) memp[d][i] <= pre(i);
        rd_q[d] <= '0;
      end else if (m_en[d]) begin
        if (m_we[d]) memp[d][m_addr[d][7:0]] <= m_wd[d];
        else         rd_q[d] <= memp[d][m_addr[d][7:0]];
      end
    end
  end

  // Transaction model: a grant in an IDLE cycle at offset 0 gives mem_en on 1..L and ready at L+1.
  typedef struct {
    bit          busy;
    int          off;
    bit          own_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          starve;
    logic [31:0] crd;
    logic [31:0] drd;
    bit          ck;
    bit          dk;
  } mdl_t;

  mdl_t        m       [2];
  logic [31:0] ref_mem [2][256];

  task automatic model_step(input int d);
    int    L;
    bit    e_en, done, cr, dr, gd;
    string p;
    L = (d == 0) ? 2 : 1;
    p = $sformatf("dut%0d", d);
    if (rst) begin
      m[d].busy = 0; m[d].off = 0; m[d].starve = 0;
      m[d].crd = '0; m[d].drd = '0; m[d].ck = 1; m[d].dk = 1;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = pre(i);
    end else if (m[d].busy) begin
      m[d].off++;
    end
    e_en = m[d].busy && (m[d].off >= 1) && (m[d].off <= L);
    done = m[d].busy && (m[d].off == L + 1);
    if (done) begin
      if (m[d].we) begin
        ref_mem[d][m[d].addr[7:0]] = m[d].wdata;
        if (m[d].own_d) m[d].dk = 0; else m[d].ck = 0;
      end else if (m[d].own_d) begin
        m[d].drd = ref_mem[d][m[d].addr[7:0]]; m[d].dk = 1;
      end else begin
        m[d].crd = ref_mem[d][m[d].addr[7:0]]; m[d].ck = 1;
      end
    end
    chk({p, ".busy"},       32'(bsy[d]),   32'(m[d].busy));
    chk({p, ".mem_en"},     32'(m_en[d]),  32'(e_en));
    chk({p, ".mem_we"},     32'(m_we[d]),  32'(e_en && m[d].we));
    chk({p, ".mem_addr"},   m_addr[d],     e_en ? m[d].addr : 32'h0);
    chk({p, ".mem_wdata"},  m_wd[d],       e_en ? m[d].wdata : 32'h0);
    chk({p, ".core_ready"}, 32'(c_rdy[d]), 32'(done && !m[d].own_d));
    chk({p, ".dbg_ready"},  32'(d_rdy[d]), 32'(done && m[d].own_d));
    if (m[d].ck) chk({p, ".core_rdata"}, c_rd[d], m[d].crd);
    if (m[d].dk) chk({p, ".dbg_rdata"},  d_rd[d], m[d].drd);
    if (!rst) begin
      if (done) begin
        m[d].busy = 0;
      end else if (!m[d].busy) begin
        cr = c_req[d];
        dr = d_req[d];
        gd = dr && (!cr || (m[d].starve == 4));
        if (cr || dr) begin
          m[d].busy  = 1;
          m[d].off   = 0;
          m[d].own_d = gd;
          m[d].we    = gd ? d_we[d]   : c_we[d];
          m[d].addr  = gd ? d_addr[d] : c_addr[d];
          m[d].wdata = gd ? d_wd[d]   : c_wd[d];
        end
        if (gd || !dr)     m[d].starve = 0;
        else if (cr && dr) m[d].starve = (m[d].starve >= 4) ? 4 : m[d].starve + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Per-cycle history of one DUT, for the hand-computed literal expectations.
  bit          h_en  [32];
  bit          h_we  [32];
  bit          h_crdy[32];
  bit          h_drdy[32];
  bit          h_busy[32];
  logic [31:0] h_addr[32];
  logic [31:0] h_wd  [32];
  logic [31:0] h_crd [32];
  logic [31:0] h_drd [32];

  task automatic record(input int d, input int n, input bit dropc, input bit dropd);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h_en[k] = m_en[d];  h_we[k] = m_we[d];  h_busy[k] = bsy[d];
      h_crdy[k] = c_rdy[d]; h_drdy[k] = d_rdy[d];
      h_addr[k] = m_addr[d]; h_wd[k] = m_wd[d];
      h_crd[k] = c_rd[d]; h_drd[k] = d_rd[d];
      @(posedge clk); #1;
      if (dropc && h_crdy[k]) c_req[d] = 1'b0;
      if (dropd && h_drdy[k]) d_req[d] = 1'b0;
    end
  endtask

  function automatic int count_crdy(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(h_crdy[k]);
    return c;
  endfunction

  function automatic int count_drdy(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(h_drdy[k]);
    return c;
  endfunction

  initial begin
    int first_dbg;
    for (int d = 0; d < 2; d++) begin
      c_req[d] = 0; c_we[d] = 0; c_addr[d] = '0; c_wd[d] = '0;
      d_req[d] = 0; d_we[d] = 0; d_addr[d] = '0; d_wd[d] = '0;
    end

    @(negedge clk);
    chk("reset.busy",       32'(bsy[0]),  32'd0);
    chk("reset.mem_en",     32'(m_en[0]), 32'd0);
    chk("reset.core_rdata", c_rd[0],      32'h0);
    chk("reset.dbg_rdata",  d_rd[0],      32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Core read of 0x10.
    c_we[0] = 0; c_addr[0] = 32'h10; c_req[0] = 1;
    record(0, 6, 1, 1);
    chk("rd.en_c0",    32'(h_en[0]),   32'd0);
    chk("rd.en_c1",    32'(h_en[1]),   32'd1);
    chk("rd.en_c2",    32'(h_en[2]),   32'd1);
    chk("rd.en_c3",    32'(h_en[3]),   32'd0);
    chk("rd.addr_c1",  h_addr[1],      32'h10);
    chk("rd.rdy_c2",   32'(h_crdy[2]), 32'd0);
    chk("rd.rdy_c3",   32'(h_crdy[3]), 32'd1);
    chk("rd.rdata_c3", h_crd[3],       32'hDEADBEEF);
    chk("rd.busy_c4",  32'(h_busy[4]), 32'd0);

    // Debug write of 0x1234 to 0x20 with the core idle.
    d_we[0] = 1; d_addr[0] = 32'h20; d_wd[0] = 32'h1234; d_req[0] = 1;
    record(0, 5, 1, 1);
    chk("dwr.we_c1",     32'(h_we[1]),          32'd1);
    chk("dwr.we_c2",     32'(h_we[2]),          32'd1);
    chk("dwr.wdata_c1",  h_wd[1],               32'h1234);
    chk("dwr.wdata_c2",  h_wd[2],               32'h1234);
    chk("dwr.dbg_rdy_n", 32'(count_drdy(0, 4)), 32'd1);
    chk("dwr.core_rdy_n", 32'(count_crdy(0, 4)), 32'd0);

    // Both requests rise together: core first, debug in the next arbitration.
    d_we[0] = 0; d_addr[0] = 32'h20; c_addr[0] = 32'h44;
    c_req[0] = 1; d_req[0] = 1;
    record(0, 8, 1, 1);
    chk("both.core_rdy_c3", 32'(h_crdy[3]), 32'd1);
    chk("both.core_rd_c3",  h_crd[3],       32'h44444444);
    chk("both.dbg_rdy_c7",  32'(h_drdy[7]), 32'd1);
    chk("both.dbg_rd_c7",   h_drd[7],       32'h1234);

    // Starvation: core held throughout, debug served after four core grants.
    c_addr[0] = 32'h10; d_addr[0] = 32'h40;
    c_req[0] = 1; d_req[0] = 1;
    record(0, 24, 0, 1);
    c_req[0] = 0;
    first_dbg = -1;
    for (int k = 23; k >= 0; k--) if (h_drdy[k]) first_dbg = k;
    chk("starve.first_dbg",   32'(first_dbg),         32'd19);
    chk("starve.core_before", 32'(count_crdy(0, 18)), 32'd4);
    chk("starve.core_c15",    32'(h_crdy[15]),        32'd1);
    chk("starve.dbg_rd_c19",  h_drd[19],              32'hA5A50040);
    chk("starve.core_c23",    32'(h_crdy[23]),        32'd1);

    // Reset in the second ACCESS cycle of a core read.
    @(posedge clk); #1;
    c_we[0] = 0; c_addr[0] = 32'h30; c_req[0] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid.en_before", 32'(m_en[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.en_after",   32'(m_en[0]),  32'd0);
    chk("rstmid.busy_after", 32'(bsy[0]),   32'd0);
    chk("rstmid.no_ready",   32'(c_rdy[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    record(0, 5, 1, 0);
    chk("rstmid.rdy_c3",   32'(h_crdy[3]),        32'd1);
    chk("rstmid.rdy_n",    32'(count_crdy(0, 4)), 32'd1);
    chk("rstmid.rdata_c3", h_crd[3],              32'h30303030);

    // MEM_LAT=1: alternating core/debug reads, back to back every 3 cycles.
    c_we[1] = 0; c_addr[1] = 32'h10; c_req[1] = 1;
    record(1, 3, 1, 0);
    chk("lat1.a_en_c1",  32'(h_en[1]),   32'd1);
    chk("lat1.a_en_c2",  32'(h_en[2]),   32'd0);
    chk("lat1.a_rdy_c2", 32'(h_crdy[2]), 32'd1);
    chk("lat1.a_crd",    h_crd[2],       32'hDEADBEEF);
    chk("lat1.a_drd",    h_drd[2],       32'h0);
    d_we[1] = 0; d_addr[1] = 32'h40; d_req[1] = 1;
    record(1, 3, 0, 1);
    chk("lat1.b_rdy_c2", 32'(h_drdy[2]), 32'd1);
    chk("lat1.b_drd",    h_drd[2],       32'hA5A50040);
    chk("lat1.b_crd",    h_crd[2],       32'hDEADBEEF);
    chk("lat1.b_nocore", 32'(count_crdy(0, 2)), 32'd0);
    c_addr[1] = 32'h44; c_req[1] = 1;
    record(1, 3, 1, 0);
    chk("lat1.c_crd", h_crd[2], 32'h44444444);
    chk("lat1.c_drd", h_drd[2], 32'hA5A50040);
    d_addr[1] = 32'h10; d_req[1] = 1;
    record(1, 3, 0, 1);
    chk("lat1.d_drd",    h_drd[2],       32'hDEADBEEF);
    chk("lat1.d_crd",    h_crd[2],       32'h44444444);
    chk("lat1.d_busy_0", 32'(h_busy[0]), 32'd0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
